// File: rtl/enc_dec_spi_sequencer.sv
// rtl/enc_dec_spi_sequencer.sv - round-robin encrypt/decrypt job sequencer over a serial slave link
// One job at a time: shift out {mode,msg,key}, wait for the slave, shift the result back in.
module enc_dec_spi_sequencer #(
    parameter int NB       = 4,
    parameter int NK       = 8,
    parameter int WAIT_CYC = 20
) (
    input  logic              in_clk,
    input  logic              in_rst,
    input  logic              req_enc,
    input  logic [32*NB-1:0]  msg_enc,
    input  logic [32*NK-1:0]  key_enc,
    input  logic              req_dec,
    input  logic [32*NB-1:0]  msg_dec,
    input  logic [32*NK-1:0]  key_dec,
    output logic              grant_enc,
    output logic              grant_dec,
    output logic              busy,
    output logic              cs_enc_dec,
    output logic              mosi,
    input  logic              miso,
    output logic [32*NB-1:0]  out_msg,
    output logic              out_valid,
    output logic              out_dst
);
    localparam int MSG_W   = 32 * NB;
    localparam int KEY_W   = 32 * NK;
    localparam int TX_BITS = 1 + MSG_W + KEY_W;
    localparam int CNT_MAX = (TX_BITS > WAIT_CYC) ? TX_BITS : WAIT_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] TX_LAST   = CNT_W'(TX_BITS - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] RX_LAST   = CNT_W'(MSG_W - 1);

    typedef enum logic [2:0] {S_IDLE, S_TX, S_WAIT, S_RX, S_DONE} state_t;

    state_t               r_state;
    state_t               w_next;
    logic [CNT_W-1:0]     r_cnt;
    logic [TX_BITS-1:0]   r_piso;
    logic [MSG_W-1:0]     r_sipo;
    logic [MSG_W-1:0]     r_out_msg;
    logic                 r_owner;
    logic                 r_last_grant;
    logic                 r_out_dst;
    logic                 w_any_req;
    logic                 w_pick;
    logic                 w_cnt_last;

    assign w_any_req = req_enc | req_dec;
    // On a tie the requester that did not win last time gets the link.
    assign w_pick    = (req_enc & req_dec) ? ~r_last_grant : req_dec;

    always_comb begin
        w_cnt_last = 1'b0;
        case (r_state)
            S_TX:    w_cnt_last = (r_cnt == TX_LAST);
            S_WAIT:  w_cnt_last = (r_cnt == WAIT_LAST);
            S_RX:    w_cnt_last = (r_cnt == RX_LAST);
            default: w_cnt_last = 1'b0;
        endcase
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_any_req) w_next = S_TX;
            S_TX:    if (w_cnt_last) w_next = S_WAIT;
            S_WAIT:  if (w_cnt_last) w_next = S_RX;
            S_RX:    if (w_cnt_last) w_next = S_DONE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            r_cnt        <= '0;
            r_piso       <= '0;
            r_sipo       <= '0;
            r_out_msg    <= '0;
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
            r_out_dst    <= 1'b0;
        end else begin
            if (w_next != r_state || r_state == S_IDLE || r_state == S_DONE)
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + 1'b1;

            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_piso       <= w_pick ? {1'b1, msg_dec, key_dec} : {1'b0, msg_enc, key_enc};
                        r_owner      <= w_pick;
                        r_last_grant <= w_pick;
                    end
                end
                S_TX: r_piso <= {r_piso[TX_BITS-2:0], 1'b0};
                S_RX: begin
                    r_sipo <= {r_sipo[MSG_W-2:0], miso};
                    // Capture includes the final miso bit so out_msg is ready in DONE.
                    if (w_cnt_last) begin
                        r_out_msg <= {r_sipo[MSG_W-2:0], miso};
                        r_out_dst <= r_owner;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        grant_enc  = 1'b0;
        grant_dec  = 1'b0;
        busy       = 1'b0;
        cs_enc_dec = 1'b1;
        mosi       = 1'b0;
        out_valid  = 1'b0;
        case (r_state)
            S_TX: begin
                busy       = 1'b1;
                cs_enc_dec = 1'b0;
                mosi       = r_piso[TX_BITS-1];
                if (r_cnt == '0) begin
                    grant_enc = ~r_owner;
                    grant_dec = r_owner;
                end
            end
            S_WAIT, S_RX: begin
                busy       = 1'b1;
                cs_enc_dec = 1'b0;
            end
            S_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
            end
            default: ;
        endcase
    end

    assign out_msg = r_out_msg;
    assign out_dst = r_out_dst;
endmodule

// File: tb/tb_enc_dec_spi_sequencer.sv
// tb/tb_enc_dec_spi_sequencer.sv - directed self-checking bench for enc_dec_spi_sequencer
module tb_enc_dec_spi_sequencer;
    logic         in_clk = 1'b0;
    logic         in_rst;
    logic         req_enc, req_dec, miso;
    logic [127:0] msg_enc, msg_dec;
    logic [255:0] key_enc, key_dec;
    logic         grant_enc, grant_dec, busy, cs_enc_dec, mosi, out_valid, out_dst;
    logic [127:0] out_msg;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int t_grant = 0;
    int t_grant_prev = 0;
    int t_valid = 0;

    localparam logic [127:0] MSG_A = 128'h00112233445566778899AABBCCDDEEFF;
    localparam logic [255:0] KEY_A = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    enc_dec_spi_sequencer dut (
        .in_clk(in_clk), .in_rst(in_rst),
        .req_enc(req_enc), .msg_enc(msg_enc), .key_enc(key_enc),
        .req_dec(req_dec), .msg_dec(msg_dec), .key_dec(key_dec),
        .grant_enc(grant_enc), .grant_dec(grant_dec), .busy(busy),
        .cs_enc_dec(cs_enc_dec), .mosi(mosi), .miso(miso),
        .out_msg(out_msg), .out_valid(out_valid), .out_dst(out_dst)
    );

    always #5 in_clk = ~in_clk;
    always @(posedge in_clk) cyc <= cyc + 1;

    task automatic run_job(input logic exp_dst, input logic [127:0] exp_msg, input logic [255:0] exp_key,
                           input logic [127:0] resp, input bit keep, input int act);
        logic [384:0] seq;
        logic [384:0] cap;
        bit           got;
        bit           quiet;
        seq   = {exp_dst, exp_msg, exp_key};
        cap   = '0;
        got   = 1'b0;
        quiet = 1'b1;
        for (int i = 0; i < 1000 && !got; i++) begin
            @(negedge in_clk);
            if (grant_enc | grant_dec) got = 1'b1;
        end
        n_cmp++;
        if (!got) begin
            n_bad++;
            $display("FAIL grant_timeout: no grant within 1000 cycles, required dst=%0d", exp_dst);
            return;
        end
        t_grant_prev = t_grant;
        t_grant      = cyc;
        n_cmp++;
        if ({grant_dec, grant_enc} !== (exp_dst ? 2'b10 : 2'b01)) begin
            n_bad++;
            $display("FAIL grant_sel: got dec/enc=%b required %b", {grant_dec, grant_enc}, (exp_dst ? 2'b10 : 2'b01));
        end
        if (!keep) begin
            if (exp_dst) req_dec = 1'b0;
            else         req_enc = 1'b0;
        end
        for (int i = 0; i < 385; i++) begin
            if (i > 0) begin
                @(negedge in_clk);
                if (grant_enc | grant_dec) quiet = 1'b0;
            end
            if (out_valid | cs_enc_dec | !busy) quiet = 1'b0;
            cap = {cap[383:0], mosi};
        end
        n_cmp++;
        if (cap !== seq) begin
            n_bad++;
            $display("FAIL tx_seq: got %h required %h", cap, seq);
        end
        for (int w = 0; w < 20; w++) begin
            @(negedge in_clk);
            if (mosi | cs_enc_dec | !busy | grant_enc | grant_dec | out_valid) quiet = 1'b0;
            if (act == 1 && w == 5) req_dec = 1'b0;
        end
        for (int j = 0; j < 128; j++) begin
            @(negedge in_clk);
            if (mosi | cs_enc_dec | !busy | grant_enc | grant_dec | out_valid) quiet = 1'b0;
            miso = resp[127-j];
            if (act == 2 && j == 10) req_enc = 1'b1;
        end
        @(negedge in_clk);
        t_valid = cyc;
        miso = 1'b0;
        n_cmp++;
        if (quiet !== 1'b1) begin
            n_bad++;
            $display("FAIL job_quiet: unexpected grant/valid/cs/mosi/busy activity mid-job, got %b required 1", quiet);
        end
        n_cmp++;
        if (out_valid !== 1'b1 || (t_valid - t_grant) != 533) begin
            n_bad++;
            $display("FAIL latency: out_valid=%b after %0d cycles, required 1 after 533", out_valid, t_valid - t_grant);
        end
        n_cmp++;
        if (out_msg !== resp || out_dst !== exp_dst) begin
            n_bad++;
            $display("FAIL result: got msg=%h dst=%b required msg=%h dst=%b", out_msg, out_dst, resp, exp_dst);
        end
        n_cmp++;
        if (cs_enc_dec !== 1'b1 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL done_ctl: got cs=%b busy=%b required cs=1 busy=1", cs_enc_dec, busy);
        end
        @(negedge in_clk);
        n_cmp++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || out_msg !== resp) begin
            n_bad++;
            $display("FAIL post_done: got busy=%b valid=%b msg=%h required 0 0 %h", busy, out_valid, out_msg, resp);
        end
    endtask

    task automatic test_reset;
        in_rst = 1'b1; req_enc = 1'b0; req_dec = 1'b0; miso = 1'b0;
        msg_enc = '0; key_enc = '0; msg_dec = '0; key_dec = '0;
        repeat (3) @(negedge in_clk);
        n_cmp++;
        if ({grant_enc, grant_dec, busy, cs_enc_dec, mosi, out_valid, out_dst} !== 7'b0001000) begin
            n_bad++;
            $display("FAIL reset_ctl: got %b required 0001000",
                     {grant_enc, grant_dec, busy, cs_enc_dec, mosi, out_valid, out_dst});
        end
        n_cmp++;
        if (out_msg !== 128'h0) begin
            n_bad++;
            $display("FAIL reset_msg: got %h required 0", out_msg);
        end
        in_rst = 1'b0;
    endtask

    task automatic test_single_enc;
        msg_enc = MSG_A; key_enc = KEY_A;
        req_enc = 1'b1;
        run_job(1'b0, MSG_A, KEY_A, ~MSG_A, 1'b0, 0);
        n_cmp++;
        if (out_msg !== 128'hFFEEDDCCBBAA99887766554433221100) begin
            n_bad++;
            $display("FAIL single_enc_value: got %h required FFEEDDCCBBAA99887766554433221100", out_msg);
        end
    endtask

    task automatic test_simultaneous;
        in_rst = 1'b1;
        @(negedge in_clk);
        in_rst = 1'b0;
        msg_dec = 128'hCAFEBABE_DEADBEEF_01234567_89ABCDEF;
        key_dec = ~KEY_A;
        req_enc = 1'b1; req_dec = 1'b1;
        run_job(1'b0, msg_enc, key_enc, ~msg_enc, 1'b1, 0);
        run_job(1'b1, msg_dec, key_dec, ~msg_dec, 1'b1, 0);
        n_cmp++;
        if (t_grant - t_grant_prev != 535) begin
            n_bad++;
            $display("FAIL rr_spacing1: got %0d required 535", t_grant - t_grant_prev);
        end
        run_job(1'b0, msg_enc, key_enc, ~msg_enc, 1'b1, 0);
        n_cmp++;
        if (t_grant - t_grant_prev != 535) begin
            n_bad++;
            $display("FAIL rr_spacing2: got %0d required 535", t_grant - t_grant_prev);
        end
        req_enc = 1'b0; req_dec = 1'b0;
    endtask

    task automatic test_dec_repeat;
        logic [127:0] m;
        for (int k = 0; k < 3; k++) begin
            m = {4{32'h1357_9BDF + 32'(k)}};
            msg_dec = m;
            req_dec = 1'b1;
            run_job(1'b1, m, key_dec, ~m, 1'b0, 0);
        end
    endtask

    task automatic test_reset_mid_job;
        bit got;
        bit quiet;
        got = 1'b0;
        quiet = 1'b1;
        req_enc = 1'b1;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge in_clk);
            if (grant_enc) got = 1'b1;
        end
        n_cmp++;
        if (!got) begin
            n_bad++;
            $display("FAIL rst_grant: no grant_enc, required one");
        end
        repeat (100) @(negedge in_clk);
        in_rst = 1'b1; req_enc = 1'b0;
        @(negedge in_clk);
        in_rst = 1'b0;
        n_cmp++;
        if (cs_enc_dec !== 1'b1 || busy !== 1'b0 || mosi !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_abort: got cs=%b busy=%b mosi=%b required 1 0 0", cs_enc_dec, busy, mosi);
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge in_clk);
            if (out_valid | grant_enc | grant_dec | busy) quiet = 1'b0;
        end
        n_cmp++;
        if (quiet !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_quiet: got activity after abort, required none");
        end
        req_enc = 1'b1;
        run_job(1'b0, msg_enc, key_enc, ~msg_enc, 1'b0, 0);
    endtask

    task automatic test_miso_pattern;
        req_dec = 1'b1;
        run_job(1'b1, msg_dec, key_dec, {16{8'hA5}}, 1'b1, 1);
        n_cmp++;
        if (out_msg !== {16{8'hA5}} || req_dec !== 1'b0) begin
            n_bad++;
            $display("FAIL a5_pattern: got %h required %h", out_msg, {16{8'hA5}});
        end
    endtask

    task automatic test_rx_request;
        int tv;
        msg_enc = 128'h0F0F_1E1E_2D2D_3C3C_4B4B_5A5A_6969_7878;
        req_dec = 1'b1;
        run_job(1'b1, msg_dec, key_dec, ~msg_dec, 1'b0, 2);
        tv = t_valid;
        run_job(1'b0, msg_enc, key_enc, ~msg_enc, 1'b0, 0);
        n_cmp++;
        if (t_grant - tv != 2) begin
            n_bad++;
            $display("FAIL pending_gap: grant %0d cycles after out_valid, required 2", t_grant - tv);
        end
    endtask

    initial begin
        test_reset;
        test_single_enc;
        test_simultaneous;
        test_dec_repeat;
        test_reset_mid_job;
        test_miso_pattern;
        test_rx_request;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/enc_dec_spi_sequencer.md
Name: enc_dec_spi_sequencer

Overview:
- Sequences one encrypt/decrypt job at a time over the serial link to the Enc/Dec slave.
- Arbitrates two requesters, the encrypt client and the decrypt client, with round-robin priority.
- Per job: serialises a mode bit, message and key on mosi; waits a fixed slave processing time; shifts the result in from miso; returns it to the granted requester.
- Link runs at in_clk; one bit per cycle.

Parameters:
- NB, 4, state columns; MSG_W = 32*NB.
- NK, 8, key words; KEY_W = 32*NK.
- WAIT_CYC, 20, slave processing cycles between last TX bit and first RX bit; must be >= 1.

Ports:
- in_clk, input, 1, sole clock; all logic on the rising edge.
- in_rst, input, 1, synchronous, active-high reset.
- req_enc, input, 1, encrypt request (level).
- msg_enc, input, MSG_W, plaintext; stable while req_enc=1 and until grant_enc.
- key_enc, input, KEY_W, encrypt key; same stability rule as msg_enc.
- req_dec, input, 1, decrypt request (level).
- msg_dec, input, MSG_W, ciphertext; same stability rule.
- key_dec, input, KEY_W, decrypt key; same stability rule.
- grant_enc, output, 1, one-cycle pulse: encrypt job accepted.
- grant_dec, output, 1, one-cycle pulse: decrypt job accepted.
- busy, output, 1, high from grant through the out_valid cycle.
- cs_enc_dec, output, 1, active-low slave select.
- mosi, output, 1, serial data to slave.
- miso, input, 1, serial data from slave.
- out_msg, output, MSG_W, result word.
- out_valid, output, 1, one-cycle pulse: out_msg valid.
- out_dst, output, 1, result owner (0 = encrypt client, 1 = decrypt client); valid with out_valid.

Behaviour:
- Reset values: grant_* = 0, busy = 0, cs_enc_dec = 1, mosi = 0, out_msg = 0, out_valid = 0, out_dst = 0, state = IDLE, last_grant = dec (so encrypt wins the first tie).
- Reset mid-job: on the next edge, return to IDLE with reset values. No out_valid. The aborted job is lost; the requester must re-request.
- FSM states: IDLE -> TX -> WAIT -> RX -> DONE -> IDLE.
- IDLE:
  - Only one requester high: grant it.
  - Both high: grant the one that is not last_grant, then update last_grant.
  - On the grant edge: load the PISO with {mode, msg, key}, where mode = 0 for encrypt and 1 for decrypt. Set the grant pulse, busy = 1, cs_enc_dec = 0, state = TX.
- TX:
  - Transmits TX_BITS = 1 + MSG_W + KEY_W bits (385 at defaults), MSB first: mode, then msg[MSG_W-1:0], then key[KEY_W-1:0].
  - mosi carries bit 0 of the sequence in the same cycle grant is high; one bit per cycle after that.
  - After the last bit, go to WAIT.
- WAIT:
  - Lasts exactly WAIT_CYC cycles.
  - mosi = 0, cs_enc_dec stays 0, miso ignored.
- RX:
  - Lasts MSG_W cycles; miso is sampled at the end of each cycle.
  - SIPO shift: sipo <= {sipo[MSG_W-2:0], miso}, so the first received bit becomes out_msg MSB.
- DONE (1 cycle):
  - out_msg = sipo, out_valid = 1, out_dst = owner, cs_enc_dec = 1, busy = 1.
  - Next cycle: busy = 0, state = IDLE.
- Latency: with grant high in cycle c0, out_valid is high in cycle c0 + TX_BITS + WAIT_CYC + MSG_W (c533 at defaults).
- Request rules:
  - Requests arriving while busy are held pending (level-sensitive) and arbitrated in the first IDLE cycle after DONE.
  - A requester dropping req mid-job has no effect on that job.
- Minimum gap: one IDLE cycle between out_valid and the next grant. A back-to-back pair therefore takes exactly TX_BITS + WAIT_CYC + MSG_W + 2 cycles between grants.
- Output hold: out_msg holds its value until the next DONE; out_dst likewise.
- Counters: one bit counter of width clog2(TX_BITS+1), reused per state and cleared on each state entry. No wrap-around is allowed within a state.
- grant_enc and grant_dec are never high together. out_valid is never high outside DONE.

Test Plan:
- Single encrypt: req_enc=1, msg=0x00112233445566778899AABBCCDDEEFF, key=0x000102...1F; slave model echoes ~msg. Required: grant_enc pulse; mosi sequence 0, msg, key (385 bits); 20 quiet cycles; out_valid after 533 cycles with out_msg=0xFFEEDDCCBBAA99887766554433221100, out_dst=0.
- Simultaneous requests after reset, both held high: required grants enc, then dec, then enc. Grant-to-grant spacing is 535 cycles; out_dst alternates 0,1,0.
- Decrypt only, requests repeated 3 times: required grant_dec every job (no starvation with enc idle); mode bit = 1 each time.
- in_rst pulsed at TX bit 100: required cs_enc_dec=1 and busy=0 on the next cycle, no out_valid, and a fresh grant after req is re-asserted.
- miso driven with pattern 0xA5 repeated, req_dec dropped at WAIT cycle 5: required out_msg=0xA5A5...A5 and out_dst=1, with unchanged timing.
- req_enc asserted during RX of a dec job: required no grant until one cycle after out_valid, then grant_enc.
